// File: rtl/mvm_seq_ctrl_if.sv
// Handshake bundle between the matrix-vector sequencer and its environment.
//   in_valid  / in_ready  : load-beat handshake (data goes straight to the datapath)
//   out_valid / out_ready : result-drain handshake (data is read from mem_y)
// master = environment side, slave = sequencer side.
interface mvm_seq_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (output in_valid, output out_ready, input in_ready, input out_valid);
  modport slave  (input in_valid, input out_ready, output in_ready, output out_valid);
endinterface

// File: rtl/mvm_seq_ctrl.sv
// Control sequencer for a KxK matrix times K-vector multiply.
// Loads A (K*K beats) and x (K beats), then walks rows issuing one MAC read
// per cycle, flushes the 3-cycle accumulate pipeline, writes y[row], and
// finally drains y through a valid/ready port.
// Ports:
//   clk, reset          : single clock, synchronous active-low reset
//   loadMatrix, loadVector, start : commands, sampled only in IDLE
//   hs (slave)          : in_valid/in_ready load handshake, out_valid/out_ready drain handshake
//   addr_a, addr_x, addr_y : memory addresses (A is row-major, addr_a = {row, col})
//   wr_en_a, wr_en_x, wr_en_y, clear_acc : datapath controls
//   done, err, busy     : status (done/err are 1-cycle pulses)
module mvm_seq_ctrl #(
  parameter int K    = 8,
  parameter int LOGK = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              loadMatrix,
  input  logic              loadVector,
  input  logic              start,
  mvm_seq_ctrl_if.slave     hs,
  output logic [2*LOGK-1:0] addr_a,
  output logic [LOGK-1:0]   addr_x,
  output logic [LOGK-1:0]   addr_y,
  output logic              wr_en_a,
  output logic              wr_en_x,
  output logic              wr_en_y,
  output logic              clear_acc,
  output logic              done,
  output logic              err,
  output logic              busy
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    LOAD_A   = 4'd1,
    LOAD_X   = 4'd2,
    MAC      = 4'd3,
    FLUSH1   = 4'd4,
    FLUSH2   = 4'd5,
    WRITE_Y  = 4'd6,
    DRAIN_RD = 4'd7,
    DRAIN    = 4'd8
  } state_t;

  localparam logic [2*LOGK-1:0] A_LAST = (2*LOGK)'(K*K-1);
  localparam logic [2*LOGK-1:0] A_ONE  = (2*LOGK)'(1);
  localparam logic [LOGK-1:0]   K_LAST = LOGK'(K-1);
  localparam logic [LOGK-1:0]   X_ONE  = LOGK'(1);

  state_t            state_r;
  logic [2*LOGK-1:0] addr_a_r;
  logic [LOGK-1:0]   addr_x_r;
  logic [LOGK-1:0]   addr_y_r;
  logic [LOGK-1:0]   row_r;
  logic              a_loaded_r;
  logic              x_loaded_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              wr_en_y_r;
  logic              clear_acc_r;
  logic              done_r;
  logic              err_r;
  logic              busy_r;
  logic              beat_s;

  // in_ready_r is high only in LOAD_A/LOAD_X, so it also gates the write enables
  // and guarantees no load write once reset has taken effect.
  assign beat_s       = in_ready_r & hs.in_valid;
  assign wr_en_a      = beat_s & (state_r == LOAD_A);
  assign wr_en_x      = beat_s & (state_r == LOAD_X);
  assign hs.in_ready  = in_ready_r;
  assign hs.out_valid = out_valid_r;
  assign addr_a       = addr_a_r;
  assign addr_x       = addr_x_r;
  assign addr_y       = addr_y_r;
  assign wr_en_y      = wr_en_y_r;
  assign clear_acc    = clear_acc_r;
  assign done         = done_r;
  assign err          = err_r;
  assign busy         = busy_r;

  // Sequencer: state, addresses, load flags and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      addr_a_r    <= '0;
      addr_x_r    <= '0;
      addr_y_r    <= '0;
      row_r       <= '0;
      a_loaded_r  <= 1'b0;
      x_loaded_r  <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      wr_en_y_r   <= 1'b0;
      clear_acc_r <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      // Single-cycle pulses default low.
      clear_acc_r <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      wr_en_y_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (a_loaded_r && x_loaded_r) begin
              state_r     <= MAC;
              row_r       <= '0;
              addr_a_r    <= '0;
              addr_x_r    <= '0;
              clear_acc_r <= 1'b1;
              busy_r      <= 1'b1;
            end else begin
              err_r <= 1'b1;
            end
          end else if (loadMatrix) begin
            state_r    <= LOAD_A;
            a_loaded_r <= 1'b0;
            addr_a_r   <= '0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b1;
          end else if (loadVector) begin
            state_r    <= LOAD_X;
            x_loaded_r <= 1'b0;
            addr_x_r   <= '0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD_A: begin
          if (beat_s) begin
            if (addr_a_r == A_LAST) begin
              a_loaded_r <= 1'b1;
              addr_a_r   <= '0;
              in_ready_r <= 1'b0;
              busy_r     <= 1'b0;
              state_r    <= IDLE;
            end else begin
              addr_a_r <= addr_a_r + A_ONE;
            end
          end
        end
        LOAD_X: begin
          if (beat_s) begin
            if (addr_x_r == K_LAST) begin
              x_loaded_r <= 1'b1;
              addr_x_r   <= '0;
              in_ready_r <= 1'b0;
              busy_r     <= 1'b0;
              state_r    <= IDLE;
            end else begin
              addr_x_r <= addr_x_r + X_ONE;
            end
          end
        end
        MAC: begin
          // addr_x doubles as the column counter; addresses hold through the flush.
          if (addr_x_r == K_LAST) begin
            state_r <= FLUSH1;
          end else begin
            addr_a_r <= addr_a_r + A_ONE;
            addr_x_r <= addr_x_r + X_ONE;
          end
        end
        FLUSH1: state_r <= FLUSH2;
        FLUSH2: begin
          state_r   <= WRITE_Y;
          wr_en_y_r <= 1'b1;
          addr_y_r  <= row_r;
        end
        WRITE_Y: begin
          if (row_r == K_LAST) begin
            addr_y_r <= '0;
            state_r  <= DRAIN_RD;
          end else begin
            row_r       <= row_r + X_ONE;
            addr_a_r    <= {row_r + X_ONE, {LOGK{1'b0}}};
            addr_x_r    <= '0;
            clear_acc_r <= 1'b1;
            state_r     <= MAC;
          end
        end
        DRAIN_RD: begin
          // One cycle for the synchronous y read before presenting it.
          state_r     <= DRAIN;
          out_valid_r <= 1'b1;
        end
        DRAIN: begin
          if (hs.out_ready) begin
            out_valid_r <= 1'b0;
            if (addr_y_r == K_LAST) begin
              addr_y_r <= '0;
              done_r   <= 1'b1;
              busy_r   <= 1'b0;
              state_r  <= IDLE;
            end else begin
              addr_y_r <= addr_y_r + X_ONE;
              state_r  <= DRAIN_RD;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// Bench for mvm_seq_ctrl: a behavioural datapath (A/x/y memories, 3-cycle
// MAC pipeline, synchronous y read) is driven by the DUT controls; a monitor
// pops scoreboard queues for every write and every drained result.
module tb_mvm_seq_ctrl;
  localparam int K = 8;

  typedef struct { int addr; int data; } exp_t;

  logic clk, reset, loadMatrix, loadVector, start;
  logic [5:0] addr_a;
  logic [2:0] addr_x, addr_y;
  logic wr_en_a, wr_en_x, wr_en_y, clear_acc, done, err, busy;
  logic [20:0] outs_s;

  mvm_seq_ctrl_if hs();

  mvm_seq_ctrl #(.K(K), .LOGK(3)) dut (
    .clk(clk), .reset(reset), .loadMatrix(loadMatrix), .loadVector(loadVector),
    .start(start), .hs(hs), .addr_a(addr_a), .addr_x(addr_x), .addr_y(addr_y),
    .wr_en_a(wr_en_a), .wr_en_x(wr_en_x), .wr_en_y(wr_en_y), .clear_acc(clear_acc),
    .done(done), .err(err), .busy(busy)
  );

  assign outs_s = {hs.in_ready, hs.out_valid, wr_en_a, wr_en_x, wr_en_y, clear_acc,
                   done, err, busy, addr_a, addr_x, addr_y};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int cnt_wa = 0, cnt_wx = 0, cnt_wy = 0, cnt_clr = 0;
  int wy_cyc [64];
  int clr_cyc [64];
  int exp_wa [$];
  int exp_wx [$];
  int exp_wy [$];
  exp_t exp_out [$];
  exp_t mon_e;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural datapath: read -> multiply -> accumulate, 3 cycles from issue.
  logic [7:0] din;
  logic signed [7:0] mem_a [64];
  logic signed [7:0] mem_x [8];
  logic [15:0] mem_y [8];
  logic signed [7:0] rd_a, rd_x;
  logic signed [15:0] prod;
  logic signed [31:0] acc;
  logic c1, c2;
  logic [15:0] dout;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_en_a) mem_a[addr_a] <= din;
    if (wr_en_x) mem_x[addr_x] <= din;
    rd_a <= mem_a[addr_a];
    rd_x <= mem_x[addr_x];
    c1   <= clear_acc;
    prod <= rd_a * rd_x;
    c2   <= c1;
    acc  <= c2 ? {{16{prod[15]}}, prod} : acc + {{16{prod[15]}}, prod};
    if (wr_en_y) mem_y[addr_y] <= acc[15:0];
    dout <= mem_y[addr_y];
  end

  // Monitor: pops expected writes/results whenever the DUT presents them.
  always @(negedge clk) begin
    if (wr_en_a | wr_en_x | wr_en_y)
      check("wr_en_exclusive", $countones({wr_en_a, wr_en_x, wr_en_y}), 1);
    if (wr_en_a) begin
      check("wr_en_a_expected", exp_wa.size() > 0, 1);
      if (exp_wa.size() > 0) check("addr_a_write", addr_a, exp_wa.pop_front());
      cnt_wa <= cnt_wa + 1;
    end
    if (wr_en_x) begin
      check("wr_en_x_expected", exp_wx.size() > 0, 1);
      if (exp_wx.size() > 0) check("addr_x_write", addr_x, exp_wx.pop_front());
      cnt_wx <= cnt_wx + 1;
    end
    if (wr_en_y) begin
      check("wr_en_y_expected", exp_wy.size() > 0, 1);
      if (exp_wy.size() > 0) check("addr_y_write", addr_y, exp_wy.pop_front());
      wy_cyc[cnt_wy] <= cyc;
      cnt_wy <= cnt_wy + 1;
    end
    if (clear_acc) begin
      check("clear_acc_col0", addr_x, 0);
      clr_cyc[cnt_clr] <= cyc;
      cnt_clr <= cnt_clr + 1;
    end
    if (hs.out_valid && hs.out_ready) begin
      check("out_expected", exp_out.size() > 0, 1);
      if (exp_out.size() > 0) begin
        mon_e = exp_out.pop_front();
        check("drain_addr_y", addr_y, mon_e.addr);
        check("drain_data", dout, mon_e.data);
      end
    end
  end

  function automatic logic [7:0] beat_val(input bit is_a, input int kind, input int i);
    if (kind == 1) return is_a ? 8'h7F : 8'h80;
    if (is_a) return ((i / K) == (i % K)) ? 8'd1 : 8'd0;
    return 8'(i + 1);
  endfunction

  task automatic send_beat(input logic [7:0] d);
    int guard;
    guard = 0;
    hs.in_valid = 1'b1;
    din = d;
    while (!hs.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) check("in_ready_timeout", hs.in_ready, 1);
    @(posedge clk); #1;
    hs.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic load_mem(input bit is_a, input int kind);
    int n, base;
    n = is_a ? K * K : K;
    base = is_a ? cnt_wa : cnt_wx;
    for (int i = 0; i < n; i++) begin
      if (is_a) exp_wa.push_back(i); else exp_wx.push_back(i);
    end
    if (is_a) loadMatrix = 1'b1; else loadVector = 1'b1;
    @(posedge clk); #1;
    loadMatrix = 1'b0;
    loadVector = 1'b0;
    check("load_busy", busy, 1);
    check("load_in_ready", hs.in_ready, 1);
    for (int i = 0; i < n; i++) send_beat(beat_val(is_a, kind, i));
    check("load_back_to_idle", busy, 0);
    check("load_beat_count", (is_a ? cnt_wa : cnt_wx) - base, n);
  endtask

  task automatic start_expect_err();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    @(posedge clk); #1;
    check("err_cleared", err, 0);
    check("err_still_idle", busy, 0);
  endtask

  task automatic run_compute(input int stall_idx);
    int bw, bc, seen;
    bit got_done;
    bw = cnt_wy;
    bc = cnt_clr;
    seen = 0;
    got_done = 1'b0;
    hs.out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("compute_busy", busy, 1);
    for (int g = 0; g < 400 && !got_done; g++) begin
      @(posedge clk); #1;
      if (done) begin
        got_done = 1'b1;
      end else if (hs.out_valid) begin
        if (seen == stall_idx) begin
          hs.out_ready = 1'b0;
          for (int s = 0; s < 5; s++) begin
            @(posedge clk); #1;
            check("stall_out_valid_held", hs.out_valid, 1);
            check("stall_addr_y_held", addr_y, stall_idx);
          end
          hs.out_ready = 1'b1;
        end
        seen++;
      end
    end
    check("done_seen", got_done, 1);
    check("outputs_drained", seen, K);
    check("exp_out_empty", exp_out.size(), 0);
    check("rows_written", cnt_wy - bw, K);
    check("clear_once_per_row", cnt_clr - bc, K);
    for (int r = 1; r < K; r++) check("wr_en_y_interval", wy_cyc[bw + r] - wy_cyc[bw + r - 1], K + 3);
    check("row0_latency", wy_cyc[bw] - clr_cyc[bc], K + 2);
    check("compute_span", wy_cyc[bw + K - 1] - clr_cyc[bc] + 1, K * (K + 3));
    @(posedge clk); #1;
    check("done_pulse_1cycle", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    int bw;
    bit found;
    reset = 1'b0;
    start = 1'b0;
    loadMatrix = 1'b0;
    loadVector = 1'b0;
    hs.in_valid = 1'b0;
    hs.out_ready = 1'b0;
    din = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_zero", outs_s, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    start_expect_err();
    check("no_writes_after_err", cnt_wa + cnt_wx + cnt_wy, 0);

    // Identity A, x = 1..8 -> y = 1..8.
    load_mem(1'b1, 0);
    load_mem(1'b0, 0);
    for (int r = 0; r < K; r++) begin
      exp_wy.push_back(r);
      exp_out.push_back('{addr: r, data: r + 1});
    end
    run_compute(-1);

    // A all 127, x all -128 -> 8 * -16256 = -130048, low 16 bits = 0x0400.
    load_mem(1'b1, 1);
    load_mem(1'b0, 1);
    for (int r = 0; r < K; r++) begin
      exp_wy.push_back(r);
      exp_out.push_back('{addr: r, data: 16'h0400});
    end
    run_compute(2);

    // Reset during row 4 of the MAC phase.
    bw = cnt_wy;
    for (int r = 0; r < 4; r++) exp_wy.push_back(r);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int g = 0; g < 200 && !found; g++) begin
      @(posedge clk); #1;
      if (clear_acc && addr_a == 6'd32) found = 1'b1;
    end
    check("reached_row4", found, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_outputs_zero", outs_s, 0);
    reset = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("writes_before_abort", cnt_wy - bw, 4);
    check("no_pending_y_writes", exp_wy.size(), 0);
    check("no_drain_after_abort", exp_out.size(), 0);
    check("idle_after_abort", busy, 0);
    start_expect_err();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
